rom_readback: RTL and testbench

// Upload-side counterpart of the SD ROM download path: serves HPS ioctl upload read requests
// by reading bytes back from the main-board ROM region map through port B of each dpram_dc.

---
 rtl/rom_readback.sv | 191 +++++++++++++++++++
 tb/tb_rom_readback.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_readback.sv
// ---------------------------------------------------------------------------
// rom_readback
//
// Serves HPS ioctl upload read requests by reading bytes back out of the
// main-board ROM regions through port B of each region's dual-clock RAM.
// Byte addresses 0x0000..LAST_ADDR map onto 4 KB regions selected by
// ADDR[15:12] (0..5 = rom_m1..rom_m6, 6..14 = bank0..bank8).
// Anything above LAST_ADDR returns FILL_BYTE without touching the RAMs.
// A running mod-256 checksum and a saturating byte count are kept per upload
// session so software can verify what was read back.
//
// Parameters
//   RAM_LATENCY  cycles from RAM_ADDR/RAM_RD valid to RAM_Q valid (1..3)
//   LAST_ADDR    highest mapped byte address
//   FILL_BYTE    byte returned for unmapped addresses
//
// Ports
//   CLK       in   1   ioctl clock
//   RESET_N   in   1   asynchronous active-low reset
//   UPLOAD    in   1   upload session active
//   RD        in   1   one-cycle read request, ADDR valid in the same cycle
//   ADDR      in   25  requested byte address
//   WAIT      out  1   request outstanding
//   DOUT      out  8   returned byte, held until the next return
//   DVALID    out  1   one-cycle pulse when DOUT is updated
//   RAM_ADDR  out  12  offset within the selected region (port B address)
//   RAM_SEL   out  4   region index used by the top level to mux q_b
//   RAM_RD    out  1   high for the single issue cycle of a mapped read
//   RAM_Q     in   8   muxed q_b of the selected region
//   CHECKSUM  out  8   mod-256 sum of bytes returned this session
//   COUNT     out  16  bytes returned this session, saturating
//   OVERRUN   out  1   sticky: RD seen while busy or while UPLOAD was low
//   STATE     out  2   debug view of the FSM (0 IDLE, 1 ISSUE, 2 LAT, 3 DONE)
//
// Handshake: RD is a single-cycle strobe accepted only in IDLE with UPLOAD
// high. WAIT rises the cycle after an accepted mapped RD and falls in the
// cycle DVALID pulses; the next RD may be presented the cycle after DVALID.
// Any RD that is not accepted is dropped and flagged on OVERRUN.
// ---------------------------------------------------------------------------
module rom_readback #(
    parameter int unsigned RAM_LATENCY = 1,
    parameter logic [24:0] LAST_ADDR   = 25'h000EFFF,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        UPLOAD,
    input  logic        RD,
    input  logic [24:0] ADDR,
    output logic        WAIT,
    output logic [7:0]  DOUT,
    output logic        DVALID,
    output logic [11:0] RAM_ADDR,
    output logic [3:0]  RAM_SEL,
    output logic        RAM_RD,
    input  logic [7:0]  RAM_Q,
    output logic [7:0]  CHECKSUM,
    output logic [15:0] COUNT,
    output logic        OVERRUN,
    output logic [1:0]  STATE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_LAT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter preload: the LAT state itself accounts for one cycle of latency.
    localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);

    state_t     state;
    logic       upload_q;
    logic [1:0] lat_cnt;

    logic upload_rise;
    logic rd_dropped;
    logic addr_mapped;

    // Session start is detected against the registered copy of UPLOAD.
    assign upload_rise = UPLOAD & ~upload_q;

    // A request is lost either because a read is in flight or because no
    // session is open; both cases are reported the same way.
    assign rd_dropped  = RD & ((state != S_IDLE) | ~UPLOAD);

    // Full-width compare so that high address bits never alias back onto
    // a region through ADDR[15:12].
    assign addr_mapped = (ADDR <= LAST_ADDR);

    assign STATE = state;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            upload_q <= 1'b0;
            lat_cnt  <= 2'd0;
            WAIT     <= 1'b0;
            DOUT     <= 8'h00;
            DVALID   <= 1'b0;
            RAM_ADDR <= 12'h000;
            RAM_SEL  <= 4'h0;
            RAM_RD   <= 1'b0;
            CHECKSUM <= 8'h00;
            COUNT    <= 16'h0000;
            OVERRUN  <= 1'b0;
        end else begin
            upload_q <= UPLOAD;

            // Strobes default low; the state that needs them raises them.
            RAM_RD <= 1'b0;
            DVALID <= 1'b0;

            // New session: clear the verification counters. A request in the
            // same cycle is still accepted below.
            if (upload_rise) begin
                CHECKSUM <= 8'h00;
                COUNT    <= 16'h0000;
                OVERRUN  <= 1'b0;
            end

            if (rd_dropped) begin
                OVERRUN <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (RD && UPLOAD) begin
                        if (addr_mapped) begin
                            // RAM_SEL/RAM_ADDR only change here, so port B
                            // stays quiet between requests.
                            RAM_SEL  <= ADDR[15:12];
                            RAM_ADDR <= ADDR[11:0];
                            RAM_RD   <= 1'b1;
                            WAIT     <= 1'b1;
                            state    <= S_ISSUE;
                        end else begin
                            // Unmapped: the fill byte is the answer, returned
                            // on the very next cycle with no RAM access.
                            DOUT   <= FILL_BYTE;
                            DVALID <= 1'b1;
                            WAIT   <= 1'b0;
                            state  <= S_DONE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (!UPLOAD) begin
                        WAIT  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_LAT;
                    end
                end

                S_LAT: begin
                    if (!UPLOAD) begin
                        // Session closed mid-read: abandon it silently,
                        // leaving DOUT and the counters untouched.
                        WAIT  <= 1'b0;
                        state <= S_IDLE;
                    end else if (lat_cnt == 2'd0) begin
                        DOUT   <= RAM_Q;
                        DVALID <= 1'b1;
                        WAIT   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end

                S_DONE: begin
                    // The byte has already been presented; account for it.
                    CHECKSUM <= CHECKSUM + DOUT;
                    if (COUNT != 16'hFFFF) begin
                        COUNT <= COUNT + 16'd1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_readback.sv
// ---------------------------------------------------------------------------
// tb_rom_readback
//
// Two instances share one clock and reset: u_l1 with RAM_LATENCY=1 and
// u_l3 with RAM_LATENCY=3. Each has its own port-B RAM model backed by one
// shared 64 KB byte image indexed by {RAM_SEL, RAM_ADDR}.
// All driving and sampling happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rom_readback;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals (index 0 = latency 1, 1 = latency 3) ----
    logic        upload   [2];
    logic        rd       [2];
    logic [24:0] addr     [2];
    logic        wait_o   [2];
    logic [7:0]  dout_o   [2];
    logic        dvalid_o [2];
    logic [11:0] raddr_o  [2];
    logic [3:0]  sel_o    [2];
    logic        ram_rd_o [2];
    logic [7:0]  ram_q    [2];
    logic [7:0]  csum_o   [2];
    logic [15:0] count_o  [2];
    logic        ovr_o    [2];
    logic [1:0]  state_o  [2];

    rom_readback #(.RAM_LATENCY(1)) u_l1 (
        .CLK(clk), .RESET_N(rst_n), .UPLOAD(upload[0]), .RD(rd[0]), .ADDR(addr[0]),
        .WAIT(wait_o[0]), .DOUT(dout_o[0]), .DVALID(dvalid_o[0]),
        .RAM_ADDR(raddr_o[0]), .RAM_SEL(sel_o[0]), .RAM_RD(ram_rd_o[0]), .RAM_Q(ram_q[0]),
        .CHECKSUM(csum_o[0]), .COUNT(count_o[0]), .OVERRUN(ovr_o[0]), .STATE(state_o[0])
    );

    rom_readback #(.RAM_LATENCY(3)) u_l3 (
        .CLK(clk), .RESET_N(rst_n), .UPLOAD(upload[1]), .RD(rd[1]), .ADDR(addr[1]),
        .WAIT(wait_o[1]), .DOUT(dout_o[1]), .DVALID(dvalid_o[1]),
        .RAM_ADDR(raddr_o[1]), .RAM_SEL(sel_o[1]), .RAM_RD(ram_rd_o[1]), .RAM_Q(ram_q[1]),
        .CHECKSUM(csum_o[1]), .COUNT(count_o[1]), .OVERRUN(ovr_o[1]), .STATE(state_o[1])
    );

    // ---------------- ROM image and port-B models ----------------
    logic [7:0] mem [0:65535];
    logic [7:0] p0;
    logic [7:0] p1_a, p1_b, p1_c;

    always @(posedge clk) begin
        p0   <= mem[{sel_o[0], raddr_o[0]}];
        p1_a <= mem[{sel_o[1], raddr_o[1]}];
        p1_b <= p1_a;
        p1_c <= p1_b;
    end
    assign ram_q[0] = p0;
    assign ram_q[1] = p1_c;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    // One read: RD for one cycle, then wait (bounded) for DVALID. lat is the
    // number of cycles from RD to DVALID (0 = never seen). Returns one cycle
    // after DVALID so the block is back in IDLE.
    task automatic rd_req(input int i, input logic [24:0] a,
                          output int lat, output logic [7:0] d,
                          output int n_ram_rd, output logic wait_first);
        lat = 0;
        d = 8'h00;
        n_ram_rd = 0;
        wait_first = 1'b0;
        rd[i] = 1'b1;
        addr[i] = a;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            rd[i] = 1'b0;
            if (k == 1) wait_first = wait_o[i];
            if (ram_rd_o[i]) n_ram_rd++;
            if (dvalid_o[i]) begin
                lat = k;
                d = dout_o[i];
                break;
            end
        end
        @(negedge clk);
    endtask

    // Count DVALID pulses over n cycles, remembering the last returned byte.
    task automatic watch(input int i, input int n, output int n_dv, output logic [7:0] d);
        n_dv = 0;
        d = 8'h00;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rd[i] = 1'b0;
            if (dvalid_o[i]) begin
                n_dv++;
                d = dout_o[i];
            end
        end
    endtask

    task automatic new_session(input int i);
        upload[i] = 1'b0;
        @(negedge clk);
        upload[i] = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int         lat;
    int         nrr;
    int         ndv;
    logic [7:0] d;
    logic       w1;

    initial begin
        for (int k = 0; k < 65536; k++) mem[k] = 8'(k * 7 + 1);
        mem[16'h0005] = 8'h3C;
        mem[16'h6FFF] = 8'h11;
        mem[16'h7000] = 8'h22;
        mem[16'hEFFF] = 8'h77;
        mem[16'h0100] = 8'h80;
        mem[16'h8200] = 8'h90;
        for (int i = 0; i < 2; i++) begin
            upload[i] = 1'b0;
            rd[i] = 1'b0;
            addr[i] = 25'h0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_wait",   32'(wait_o[0]),   32'h0);
        check("rst_dout",   32'(dout_o[0]),   32'h0);
        check("rst_dvalid", 32'(dvalid_o[0]), 32'h0);
        check("rst_raddr",  32'(raddr_o[0]),  32'h0);
        check("rst_sel",    32'(sel_o[0]),    32'h0);
        check("rst_ram_rd", 32'(ram_rd_o[0]), 32'h0);
        check("rst_csum",   32'(csum_o[0]),   32'h0);
        check("rst_count",  32'(count_o[0]),  32'h0);
        check("rst_ovr",    32'(ovr_o[0]),    32'h0);
        check("rst_state",  32'(state_o[0]),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        upload[0] = 1'b1;
        upload[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // 1) single mapped read in rom_m1
        rd_req(0, 25'h0005, lat, d, nrr, w1);
        check("t1_lat",    32'(lat),         32'd3);
        check("t1_dout",   32'(d),           32'h3C);
        check("t1_ram_rd", 32'(nrr),         32'd1);
        check("t1_wait",   32'(w1),          32'h1);
        check("t1_sel",    32'(sel_o[0]),    32'h0);
        check("t1_raddr",  32'(raddr_o[0]),  32'h005);
        check("t1_pulse",  32'(dvalid_o[0]), 32'h0);
        check("t1_wait_lo",32'(wait_o[0]),   32'h0);
        check("t1_csum",   32'(csum_o[0]),   32'h3C);
        check("t1_count",  32'(count_o[0]),  32'd1);

        // 2) region boundary rom_m... bank0 -> bank1
        new_session(0);
        check("t2_count0", 32'(count_o[0]), 32'd0);
        rd_req(0, 25'h6FFF, lat, d, nrr, w1);
        check("t2_dout_a", 32'(d),          32'h11);
        check("t2_sel_a",  32'(sel_o[0]),   32'h6);
        check("t2_raddr_a",32'(raddr_o[0]), 32'hFFF);
        rd_req(0, 25'h7000, lat, d, nrr, w1);
        check("t2_dout_b", 32'(d),          32'h22);
        check("t2_sel_b",  32'(sel_o[0]),   32'h7);
        check("t2_csum",   32'(csum_o[0]),  32'h33);
        check("t2_count",  32'(count_o[0]), 32'd2);

        // 3) last mapped byte, then unmapped addresses (no aliasing)
        rd_req(0, 25'h0EFFF, lat, d, nrr, w1);
        check("t3_dout_a", 32'(d),          32'h77);
        check("t3_lat_a",  32'(lat),        32'd3);
        check("t3_sel_a",  32'(sel_o[0]),   32'hE);
        rd_req(0, 25'h0F000, lat, d, nrr, w1);
        check("t3_dout_b", 32'(d),          32'hFF);
        check("t3_lat_b",  32'(lat),        32'd1);
        check("t3_rrd_b",  32'(nrr),        32'd0);
        check("t3_wait_b", 32'(w1),         32'h0);
        rd_req(0, 25'h10000, lat, d, nrr, w1);
        check("t3_dout_c", 32'(d),          32'hFF);
        check("t3_lat_c",  32'(lat),        32'd1);
        check("t3_rrd_c",  32'(nrr),        32'd0);
        check("t3_sel_c",  32'(sel_o[0]),   32'hE);
        check("t3_csum",   32'(csum_o[0]),  32'hA8);
        check("t3_count",  32'(count_o[0]), 32'd5);
        check("t3_ovr",    32'(ovr_o[0]),   32'h0);

        // 4) second RD one cycle after the first
        new_session(0);
        rd[0] = 1'b1;
        addr[0] = 25'h0005;
        @(negedge clk);
        addr[0] = 25'h6FFF;
        @(negedge clk);
        rd[0] = 1'b0;
        watch(0, 8, ndv, d);
        check("t4_ndv",   32'(ndv),         32'd1);
        check("t4_dout",  32'(d),           32'h3C);
        check("t4_ovr",   32'(ovr_o[0]),    32'h1);
        check("t4_count", 32'(count_o[0]),  32'd1);

        // 5) UPLOAD dropped while waiting on the RAM
        rd[0] = 1'b1;
        addr[0] = 25'h6FFF;
        @(negedge clk);
        rd[0] = 1'b0;
        @(negedge clk);
        check("t5_in_lat", 32'(state_o[0]), 32'd2);
        upload[0] = 1'b0;
        @(negedge clk);
        check("t5_wait",   32'(wait_o[0]),   32'h0);
        check("t5_state",  32'(state_o[0]),  32'd0);
        check("t5_dv0",    32'(dvalid_o[0]), 32'h0);
        watch(0, 6, ndv, d);
        check("t5_ndv",    32'(ndv),         32'd0);
        check("t5_count",  32'(count_o[0]),  32'd1);
        check("t5_csum",   32'(csum_o[0]),   32'h3C);
        check("t5_dout",   32'(dout_o[0]),   32'h3C);

        // 5b) UPLOAD rise together with RD: clear and accept
        upload[0] = 1'b1;
        rd_req(0, 25'h7000, lat, d, nrr, w1);
        check("t5b_lat",   32'(lat),         32'd3);
        check("t5b_dout",  32'(d),           32'h22);
        check("t5b_count", 32'(count_o[0]),  32'd1);
        check("t5b_csum",  32'(csum_o[0]),   32'h22);
        check("t5b_ovr",   32'(ovr_o[0]),    32'h0);

        // 5c) RD with no session open
        upload[0] = 1'b0;
        @(negedge clk);
        rd[0] = 1'b1;
        addr[0] = 25'h0005;
        watch(0, 5, ndv, d);
        check("t5c_ndv",   32'(ndv),         32'd0);
        check("t5c_ovr",   32'(ovr_o[0]),    32'h1);
        check("t5c_count", 32'(count_o[0]),  32'd1);

        // 6) latency-3 instance, checksum wrap
        rd_req(1, 25'h0100, lat, d, nrr, w1);
        check("t6_lat_a",  32'(lat),         32'd5);
        check("t6_dout_a", 32'(d),           32'h80);
        check("t6_rrd_a",  32'(nrr),         32'd1);
        rd_req(1, 25'h8200, lat, d, nrr, w1);
        check("t6_lat_b",  32'(lat),         32'd5);
        check("t6_dout_b", 32'(d),           32'h90);
        check("t6_csum",   32'(csum_o[1]),   32'h10);
        check("t6_count",  32'(count_o[1]),  32'd2);

        // 7) asynchronous reset during the issue cycle
        upload[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd[0] = 1'b1;
        addr[0] = 25'h7000;
        @(negedge clk);
        rd[0] = 1'b0;
        check("t7_ram_rd", 32'(ram_rd_o[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_wait",   32'(wait_o[0]),   32'h0);
        check("t7_rrd",    32'(ram_rd_o[0]), 32'h0);
        check("t7_sel",    32'(sel_o[0]),    32'h0);
        check("t7_dout",   32'(dout_o[0]),   32'h0);
        check("t7_csum",   32'(csum_o[0]),   32'h0);
        check("t7_state",  32'(state_o[0]),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
